regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the 32x32, 2-read/1-write register file in the pipeline CPU's decode stage.
- Generalised in data width, depth and read-port count.
- Adds an optional hardwired zero register and a multi-cycle bulk-clear sequencer with a busy flag.
- Optional write-to-read bypass, so decode sees a same-cycle writeback without external forwarding.

---
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 125 ++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port register file with bulk-clear sweep; define REGFILE_BYPASS_EN for write-first bypass
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     RegWr,
  input  logic [ADDR_W-1:0]        Rw,
  input  logic [DATA_W-1:0]        busW,
  input  logic [NUM_RD*ADDR_W-1:0] Ra,
  output logic [NUM_RD*DATA_W-1:0] busA,
  input  logic                     Clr,
  output logic                     Busy
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic wr_ok;
  assign Busy  = state == SWEEP;
  assign wr_ok = state == IDLE && RegWr && !(ZERO_REG != 0 && Rw == '0);
  // state, sweep counter and array updates; reset clears everything and aborts a sweep
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (wr_ok) mem[Rw] <= busW;
      if (state == SWEEP) mem[cnt] <= '0;
    end
  end
  // sweep sequencing: Clr starts from entry 0, exit on the edge that clears the last entry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE && Clr) begin
      state_nxt = SWEEP;
      cnt_nxt   = '0;
    end else if (state == SWEEP) begin
      cnt_nxt   = cnt + 1'b1;
      state_nxt = &cnt ? IDLE : SWEEP;
    end
  end
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              z;
    logic              byp;
    assign a = Ra[g*ADDR_W +: ADDR_W];
    assign z = Reset || Busy || (ZERO_REG != 0 && a == '0);
`ifdef REGFILE_BYPASS_EN
    assign byp = state == IDLE && RegWr && Rw == a;
`else
    assign byp = 1'b0;
`endif
    assign busA[g*DATA_W +: DATA_W] = z ? '0 : byp ? busW : mem[a];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array reference model
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 2**AW;
  logic CLK = 0, Reset, RegWr, Clr, Busy;
  logic [AW-1:0] Rw;
  logic [DW-1:0] busW;
  logic [NR*AW-1:0] Ra;
  logic [NR*DW-1:0] busA;
  typedef struct {
    logic [NR*DW-1:0] a;
    logic             b;
    string            tag;
  } exp_t;
  exp_t q[$];
  logic [DW-1:0] mem [DEPTH];
  int sweep_left = 0;
  int vectors = 0, miscompares = 0;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .CLK(CLK), .Reset(Reset), .RegWr(RegWr), .Rw(Rw), .busW(busW),
    .Ra(Ra), .busA(busA), .Clr(Clr), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // monitor: compare the presented read data and Busy against the queued expectation
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (busA !== e.a || Busy !== e.b) begin
        miscompares++;
        $display("FAIL %s: busA=%h Busy=%b, expected busA=%h Busy=%b", e.tag, busA, Busy, e.a, e.b);
      end
    end
  end

  task automatic step(input logic rst, input logic wr, input logic [AW-1:0] rw,
                      input logic [DW-1:0] w, input logic [NR*AW-1:0] ra,
                      input logic clr, input string tag);
    exp_t e;
    Reset = rst; RegWr = wr; Rw = rw; busW = w; Ra = ra; Clr = clr;
    e.a = '0;
    e.b = sweep_left > 0;
    e.tag = tag;
    for (int l = 0; l < NR; l++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] v;
      a = ra[l*AW +: AW];
      v = mem[a];
`ifdef REGFILE_BYPASS_EN
      if (wr && rw == a) v = w;
`endif
      if (rst || sweep_left > 0 || a == 0) v = '0;
      e.a[l*DW +: DW] = v;
    end
    q.push_back(e);
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      sweep_left = 0;
    end else if (sweep_left > 0) begin
      mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (wr && rw != 0) mem[rw] = w;
      if (clr) sweep_left = DEPTH;
    end
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input string tag);
    step(0, 0, '0, '0, {a1, a0}, 0, tag);
  endtask

  initial begin
    Reset = 1; RegWr = 0; Clr = 0; Rw = '0; busW = '0; Ra = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    @(posedge CLK);
    #1;
    step(1, 1, 5'd9, 32'h1111_2222, {5'd9, 5'd9}, 1, "reset_forced_zero");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), AW'(DEPTH-1-a), "reset_read_all");
    step(0, 1, 5'd5, 32'hDEAD_BEEF, {5'd1, 5'd2}, 0, "write5");
    rd(5'd5, 5'd5, "read5_both_lanes");
    step(0, 1, 5'd0, 32'h0000_1234, {5'd0, 5'd0}, 0, "write_zero_reg");
    rd(5'd0, 5'd5, "read_zero_reg");
    step(0, 1, 5'd7, 32'hCAFE_F00D, {5'd7, 5'd7}, 0, "same_cycle_write7");
    rd(5'd7, 5'd0, "read7_after");
    for (int a = 0; a < DEPTH; a++)
      step(0, 1, AW'(a), DW'(a+1), {AW'(a), AW'($urandom)}, 0, "fill");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), AW'(a), "fill_read");
    step(0, 0, '0, '0, {5'd3, 5'd4}, 1, "clr_pulse");
    for (int c = 0; c < DEPTH; c++)
      step(0, 1, AW'($urandom), 32'h55, {AW'($urandom), AW'(c)}, c[2], "sweep_write_dropped");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), AW'(DEPTH-1-a), "post_sweep_read");
    for (int a = 1; a < DEPTH; a++) step(0, 1, AW'(a), $urandom, '0, 0, "refill");
    step(0, 0, '0, '0, '0, 1, "clr_again");
    for (int c = 0; c < 10; c++) step(0, 0, '0, '0, AW'(c), 0, "sweep_run");
    step(1, 1, 5'd4, 32'h77, {5'd20, 5'd21}, 0, "reset_mid_sweep");
    for (int a = 0; a < DEPTH; a++) rd(AW'(a), AW'(a ^ 5), "after_abort_read");
    step(0, 1, 5'd3, 32'hA5, {5'd3, 5'd2}, 0, "write3_after_abort");
    rd(5'd3, 5'd3, "read3_after_abort");
    step(0, 1, 5'd12, 32'h0BAD_CAFE, {5'd12, 5'd0}, 1, "clr_with_write");
    for (int c = 0; c < DEPTH; c++) rd(5'd12, AW'(c), "clr_with_write_sweep");
    rd(5'd12, 5'd3, "clr_with_write_cleared");
    for (int n = 0; n < 3000; n++) begin
      logic r, w, c;
      r = $urandom_range(0, 99) == 0;
      w = $urandom_range(0, 1) == 1;
      c = $urandom_range(0, 59) == 0;
      step(r, w, AW'($urandom), $urandom, NR*AW'($urandom), c, "random");
    end
    rd(5'd1, 5'd2, "drain");
    @(negedge CLK);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
